// File: rtl/tc_sound_pkg.sv
// Shared constants, INT state encoding and latch encoding for the sound latch block.
// Optional build macro SOUND_LATCH_OVERRUN_EN is used by sound_latch_irq.
package tc_sound_pkg;

   localparam int         IRQ_DIV_DEFAULT = 512;
   localparam logic [7:0] LATCH_CLEAR_VAL = 8'h00;

   typedef enum logic {
      INT_IDLE     = 1'b0,
      INT_ASSERTED = 1'b1
   } int_state_t;

   // Bit 7 of the 68K byte never reaches the Z80; bit 0 is always set so a
   // written command can be told apart from a cleared latch.
   function automatic logic [7:0] latch_encode(input logic [7:0] d);
      logic unused_msb;
      unused_msb = d[7];
      return {d[6:0], 1'b1};
   endfunction

endpackage

// File: rtl/sound_latch_irq_if.sv
// Bus bundle between the address decoder / CPUs (master) and the sound latch block (slave).
// Optional build macro SOUND_LATCH_OVERRUN_EN does not change this interface.
interface sound_latch_irq_if;

   logic [15:0] m68k_dout;
   logic        m68k_rw;
   logic        m68k_lds_n;
   logic        sound_latch_cs;
   logic        z80_latch_r_cs;
   logic        z80_latch_clr_cs;
   logic        z80_M1_n;
   logic        z80_IORQ_n;
   logic [7:0]  latch_dout;
   logic        latch_pending;
   logic        z80_int_n;
   logic        int_ack;

   modport master (
      output m68k_dout, m68k_rw, m68k_lds_n, sound_latch_cs,
             z80_latch_r_cs, z80_latch_clr_cs, z80_M1_n, z80_IORQ_n,
      input  latch_dout, latch_pending, z80_int_n, int_ack
   );

   modport slave (
      input  m68k_dout, m68k_rw, m68k_lds_n, sound_latch_cs,
             z80_latch_r_cs, z80_latch_clr_cs, z80_M1_n, z80_IORQ_n,
      output latch_dout, latch_pending, z80_int_n, int_ack
   );

endinterface

// File: rtl/z80_irq_timer.sv
// Periodic Z80 maskable-interrupt generator: 16-bit enable counter plus IDLE/ASSERTED INT FSM.
// Optional build macro SOUND_LATCH_OVERRUN_EN has no effect here.
module z80_irq_timer
   import tc_sound_pkg::*;
#(
   parameter int IRQ_DIV = IRQ_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clk_en_z80,
   input  logic ack,
   output logic z80_int_n,
   output logic int_ack
);

   localparam logic [15:0] TIMER_LAST = 16'(IRQ_DIV - 1);

   logic [15:0] timer_reg, timer_next;
   int_state_t  state_reg, state_next;
   logic        int_ack_reg, int_ack_next;
   logic        irq_req;
   logic        ack_take;

   assign irq_req  = clk_en_z80 & (timer_reg == TIMER_LAST);
   assign ack_take = clk_en_z80 & ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_reg   <= '0;
         state_reg   <= INT_IDLE;
         int_ack_reg <= 1'b0;
      end else begin
         timer_reg   <= timer_next;
         state_reg   <= state_next;
         int_ack_reg <= int_ack_next;
      end
   end

   // Requests arriving while ASSERTED (or on the ack clk) are simply dropped.
   always_comb begin
      timer_next   = timer_reg;
      state_next   = state_reg;
      int_ack_next = 1'b0;
      if (clk_en_z80) begin
         timer_next = (timer_reg == TIMER_LAST) ? 16'd0 : timer_reg + 16'd1;
      end
      case (state_reg)
         INT_IDLE: begin
            if (irq_req) begin
               state_next = INT_ASSERTED;
            end
         end
         INT_ASSERTED: begin
            if (ack_take) begin
               state_next   = INT_IDLE;
               int_ack_next = 1'b1;
            end
         end
      endcase
   end

   assign z80_int_n = (state_reg != INT_ASSERTED);
   assign int_ack   = int_ack_reg;

endmodule

// File: rtl/sound_latch_irq.sv
// 68K-to-Z80 sound command latch with pending flag and periodic Z80 INT generation.
// Define SOUND_LATCH_OVERRUN_EN to add the debug overrun_cnt output.
module sound_latch_irq
   import tc_sound_pkg::*;
#(
   parameter int IRQ_DIV = IRQ_DIV_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en_z80,
   sound_latch_irq_if.slave bus
`ifdef SOUND_LATCH_OVERRUN_EN
   ,
   output logic [7:0]       overrun_cnt
`endif
);

   logic       wr_strobe;
   logic       wr_strobe_reg;
   logic       wr_take;
   logic       rd_take;
   logic       clr_take;
   logic       ack_cycle;
   logic [7:0] latch_reg;
   logic       pending_reg;
   logic       unused_hi;

   assign unused_hi = &{1'b0, bus.m68k_dout[15:8]};

   assign wr_strobe = bus.sound_latch_cs & ~bus.m68k_rw & ~bus.m68k_lds_n;
   assign wr_take   = wr_strobe & ~wr_strobe_reg;
   assign rd_take   = clk_en_z80 & bus.z80_latch_r_cs;
   assign clr_take  = clk_en_z80 & bus.z80_latch_clr_cs;

   // A fresh 68K write beats any Z80 read/clear landing on the same clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_strobe_reg <= 1'b0;
         latch_reg     <= LATCH_CLEAR_VAL;
         pending_reg   <= 1'b0;
      end else begin
         wr_strobe_reg <= wr_strobe;
         if (wr_take) begin
            latch_reg   <= latch_encode(bus.m68k_dout[7:0]);
            pending_reg <= 1'b1;
         end else if (clr_take) begin
            latch_reg   <= LATCH_CLEAR_VAL;
            pending_reg <= 1'b0;
         end else if (rd_take) begin
            pending_reg <= 1'b0;
         end
      end
   end

   assign bus.latch_dout    = latch_reg;
   assign bus.latch_pending = pending_reg;

`ifdef SOUND_LATCH_OVERRUN_EN
   logic [7:0] overrun_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_reg <= 8'h00;
      end else if (wr_take && pending_reg && (overrun_reg != 8'hFF)) begin
         overrun_reg <= overrun_reg + 8'd1;
      end
   end

   assign overrun_cnt = overrun_reg;
`endif

   assign ack_cycle = ~bus.z80_M1_n & ~bus.z80_IORQ_n;

   z80_irq_timer #(
      .IRQ_DIV (IRQ_DIV)
   ) u_irq_timer (
      .clk        (clk),
      .reset      (reset),
      .clk_en_z80 (clk_en_z80),
      .ack        (ack_cycle),
      .z80_int_n  (bus.z80_int_n),
      .int_ack    (bus.int_ack)
   );

endmodule

// File: tb/tb_sound_latch_irq.sv
// Directed scoreboard bench for sound_latch_irq (IRQ_DIV = 8).
// Build with SOUND_LATCH_OVERRUN_EN to also exercise overrun_cnt.
module tb_sound_latch_irq;

   localparam int DIV = 8;

   logic clk = 1'b0;
   logic reset;
   logic clk_en_z80;

   sound_latch_irq_if bus ();

`ifdef SOUND_LATCH_OVERRUN_EN
   logic [7:0] overrun_cnt;
`endif

   sound_latch_irq #(
      .IRQ_DIV (DIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en_z80 (clk_en_z80),
      .bus        (bus)
`ifdef SOUND_LATCH_OVERRUN_EN
      ,
      .overrun_cnt(overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   // chk bits: [3] latch_dout, [2] latch_pending, [1] z80_int_n, [0] int_ack
   typedef struct packed {
      logic [3:0] chk;
      logic [7:0] dout;
      logic       pend;
      logic       int_n;
      logic       ack;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic cmp(string tag, logic [7:0] obs, logic [7:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(string tag, logic [3:0] chk, logic [7:0] d, logic p, logic i, logic a);
      exp_t e;
      e.chk   = chk;
      e.dout  = d;
      e.pend  = p;
      e.int_n = i;
      e.ack   = a;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic pop_check();
      exp_t  e;
      string t;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      $display("[%0t] %s dout=%h pend=%b int_n=%b ack=%b", $time, t,
               bus.latch_dout, bus.latch_pending, bus.z80_int_n, bus.int_ack);
      if (e.chk[3]) cmp({t, ".dout"},  bus.latch_dout,           e.dout);
      if (e.chk[2]) cmp({t, ".pend"},  {7'd0, bus.latch_pending}, {7'd0, e.pend});
      if (e.chk[1]) cmp({t, ".int_n"}, {7'd0, bus.z80_int_n},     {7'd0, e.int_n});
      if (e.chk[0]) cmp({t, ".ack"},   {7'd0, bus.int_ack},       {7'd0, e.ack});
   endtask

   task automatic step(string tag, logic [3:0] chk, logic [7:0] d, logic p, logic i, logic a);
      push_exp(tag, chk, d, p, i, a);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic now_check(string tag, logic [3:0] chk, logic [7:0] d, logic p, logic i, logic a);
      push_exp(tag, chk, d, p, i, a);
      #1;
      pop_check();
   endtask

   task automatic idle_bus();
      bus.sound_latch_cs   = 1'b0;
      bus.m68k_rw          = 1'b1;
      bus.m68k_lds_n       = 1'b1;
      bus.z80_latch_r_cs   = 1'b0;
      bus.z80_latch_clr_cs = 1'b0;
      bus.z80_M1_n         = 1'b1;
      bus.z80_IORQ_n       = 1'b1;
   endtask

   task automatic m68k_wr(logic [15:0] d);
      bus.sound_latch_cs = 1'b1;
      bus.m68k_rw        = 1'b0;
      bus.m68k_lds_n     = 1'b0;
      bus.m68k_dout      = d;
   endtask

   task automatic ack_on(logic on);
      bus.z80_M1_n   = ~on;
      bus.z80_IORQ_n = ~on;
   endtask

   initial begin
      idle_bus();
      bus.m68k_dout = 16'h0000;
      clk_en_z80    = 1'b0;
      reset         = 1'b1;
      #12;
      now_check("reset_hold", 4'b1111, 8'h00, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step("idle_after_reset", 4'b1111, 8'h00, 1'b0, 1'b1, 1'b0);

      // Latch write, edge-qualified
      m68k_wr(16'h00A5);
      step("wr_a5", 4'b1111, 8'h4B, 1'b1, 1'b1, 1'b0);
      bus.m68k_dout = 16'h0033;
      for (int k = 0; k < 6; k++) step("wr_hold", 4'b1100, 8'h4B, 1'b1, 1'b0, 1'b0);
      idle_bus();
      step("wr_release", 4'b1100, 8'h4B, 1'b1, 1'b0, 1'b0);

      // Z80 read / clear, enable-qualified
      bus.z80_latch_r_cs = 1'b1;
      step("rd_no_en", 4'b1100, 8'h4B, 1'b1, 1'b0, 1'b0);
      clk_en_z80 = 1'b1;
      step("rd_en", 4'b1100, 8'h4B, 1'b0, 1'b0, 1'b0);
      bus.z80_latch_r_cs   = 1'b0;
      bus.z80_latch_clr_cs = 1'b1;
      step("clr_en", 4'b1100, 8'h00, 1'b0, 1'b0, 1'b0);
      clk_en_z80 = 1'b0;
      idle_bus();

      // Non-write bus cycles
      bus.sound_latch_cs = 1'b1;
      bus.m68k_rw        = 1'b1;
      bus.m68k_lds_n     = 1'b0;
      bus.m68k_dout      = 16'h0077;
      step("m68k_read_no_wr", 4'b1100, 8'h00, 1'b0, 1'b0, 1'b0);
      bus.m68k_rw    = 1'b0;
      bus.m68k_lds_n = 1'b1;
      step("lds_high_no_wr", 4'b1100, 8'h00, 1'b0, 1'b0, 1'b0);
      idle_bus();
      m68k_wr(16'h0080);
      step("wr_bit7_dropped", 4'b1100, 8'h01, 1'b1, 1'b0, 1'b0);
      idle_bus();
      step("gap1", 4'b1100, 8'h01, 1'b1, 1'b0, 1'b0);

      // Write collides with clear, then with read
      m68k_wr(16'h005A);
      bus.z80_latch_clr_cs = 1'b1;
      clk_en_z80           = 1'b1;
      step("wr_vs_clr", 4'b1100, 8'hB5, 1'b1, 1'b0, 1'b0);
      idle_bus();
      clk_en_z80 = 1'b0;
      step("gap2", 4'b1100, 8'hB5, 1'b1, 1'b0, 1'b0);
      bus.z80_latch_r_cs = 1'b1;
      clk_en_z80         = 1'b1;
      step("rd_b5", 4'b1100, 8'hB5, 1'b0, 1'b0, 1'b0);
      idle_bus();
      m68k_wr(16'h0011);
      bus.z80_latch_r_cs = 1'b1;
      step("wr_vs_rd", 4'b1100, 8'h23, 1'b1, 1'b0, 1'b0);
      idle_bus();
      clk_en_z80 = 1'b0;
      step("gap3", 4'b1100, 8'h23, 1'b1, 1'b0, 1'b0);

      // Interrupt timer with continuous enables
      #2;
      reset = 1'b1;
      now_check("reset_pre_timer", 4'b1111, 8'h00, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      reset      = 1'b0;
      clk_en_z80 = 1'b1;
      for (int k = 1; k <= 7; k++) step("int_wait", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b0);
      step("int_fall_8", 4'b0011, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 9; k <= 32; k++) step("int_hold_noq", 4'b0011, 8'h00, 1'b0, 1'b0, 1'b0);
      ack_on(1'b1);
      step("ack_33", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b1);
      ack_on(1'b0);
      step("ack_pulse_end", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b0);
      ack_on(1'b1);
      step("ack_while_idle", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b0);
      ack_on(1'b0);
      for (int k = 36; k <= 39; k++) step("int_rearm", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b0);
      step("int_fall_40", 4'b0011, 8'h00, 1'b0, 1'b0, 1'b0);
      clk_en_z80 = 1'b0;
      ack_on(1'b1);
      step("ack_no_en", 4'b0011, 8'h00, 1'b0, 1'b0, 1'b0);
      clk_en_z80 = 1'b1;
      step("ack_41", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b1);
      ack_on(1'b0);
      for (int k = 42; k <= 47; k++) step("int_wait2", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b0);
      step("int_fall_48", 4'b0011, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 49; k <= 55; k++) step("int_hold2", 4'b0011, 8'h00, 1'b0, 1'b0, 1'b0);
      ack_on(1'b1);
      step("ack_with_req_56", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b1);
      ack_on(1'b0);
      for (int k = 57; k <= 63; k++) step("req_dropped", 4'b0011, 8'h00, 1'b0, 1'b1, 1'b0);
      step("int_fall_64", 4'b0011, 8'h00, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset while INT asserted and latch pending
      m68k_wr(16'h0042);
      step("wr_during_int", 4'b1111, 8'h85, 1'b1, 1'b0, 1'b0);
      idle_bus();
      #2;
      reset = 1'b1;
      now_check("async_reset", 4'b1111, 8'h00, 1'b0, 1'b1, 1'b0);
      step("reset_held", 4'b1111, 8'h00, 1'b0, 1'b1, 1'b0);
      reset      = 1'b0;
      clk_en_z80 = 1'b0;

`ifdef SOUND_LATCH_OVERRUN_EN
      m68k_wr(16'h0001);
      @(posedge clk);
      #1;
      cmp("overrun_first_wr", overrun_cnt, 8'h00);
      idle_bus();
      @(posedge clk);
      #1;
      for (int k = 1; k < 300; k++) begin
         m68k_wr(16'(k));
         @(posedge clk);
         #1;
         idle_bus();
         @(posedge clk);
         #1;
         if (k == 5) cmp("overrun_5", overrun_cnt, 8'h05);
      end
      cmp("overrun_sat", overrun_cnt, 8'hFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sound_latch_irq.md
Name: sound_latch_irq

Overview:
- Consumes the M68K sound-latch select and the Z80 latch-read and latch-clear selects produced by the address decoder.
- Holds the 68K-to-Z80 sound command byte and tracks whether the Z80 has consumed it.
- Generates the Z80 periodic maskable interrupt and handles its IM1 acknowledge.
- Sits between the address-decode stage and the Z80 sound CPU data-in mux.

Parameters:
- IRQ_DIV, 512, number of Z80 clock-enable pulses between periodic INT requests; must be 2..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en_z80  in  1  Z80 clock-enable pulse, one clk wide
- m68k_dout  in  16  M68K write data
- m68k_rw  in  1  M68K read/write (1 = read)
- m68k_lds_n  in  1  M68K lower data strobe, active low
- sound_latch_cs  in  1  decoded M68K sound-latch select
- z80_latch_r_cs  in  1  decoded Z80 I/O read of latch (port 06)
- z80_latch_clr_cs  in  1  decoded Z80 I/O latch clear (port 04)
- z80_M1_n  in  1  Z80 M1, active low
- z80_IORQ_n  in  1  Z80 IORQ, active low
- latch_dout  out  8  latch value to Z80 data-in mux
- latch_pending  out  1  latch written and not yet read or cleared
- z80_int_n  out  1  Z80 INT, active low
- int_ack  out  1  one-clk pulse on accepted interrupt acknowledge

Behaviour:
- Reset (asynchronous, active-high) forces all state and outputs to these values, from any state including mid-count or mid-interrupt:
  - latch_dout = 8'h00, latch_pending = 0
  - z80_int_n = 1, int_ack = 0
  - timer = 0, write-edge register = 0
- wr_strobe = sound_latch_cs & !m68k_rw & !m68k_lds_n.
- Write is taken on the clk where wr_strobe is 1 and its registered copy is 0, i.e. exactly once per bus cycle.
- On a write:
  - latch_dout <= {m68k_dout[6:0], 1'b1}, and m68k_dout[7] is discarded.
  - latch_pending <= 1.
  - Visible one clk after the write edge.
- Z80 latch read:
  - Qualified by z80_latch_r_cs on a clk_en_z80 clk.
  - Clears latch_pending; latch_dout is unchanged.
  - latch_dout is driven combinationally from the register at all times; the Z80 side mux selects it.
- Z80 clear:
  - Qualified by z80_latch_clr_cs on a clk_en_z80 clk.
  - Sets latch_dout <= 8'h00 and latch_pending <= 0.
- Simultaneous 68K write and Z80 read or clear on the same clk: the write wins, latch holds new data, pending = 1.
- Timer:
  - 16-bit counter, advances only on clk_en_z80.
  - At IRQ_DIV-1 it wraps to 0 and raises an INT request, so the first INT occurs on the IRQ_DIV-th enable after reset.
- INT state machine:
  - States: IDLE (z80_int_n = 1) and ASSERTED (z80_int_n = 0).
  - IDLE -> ASSERTED on an INT request.
  - ASSERTED -> IDLE on the clk_en_z80 clk where z80_M1_n = 0 and z80_IORQ_n = 0. int_ack pulses high for that one clk.
- INT request while already ASSERTED: no effect. Requests do not queue, and the timer keeps running independently.
- Acknowledge in the same clk as a new request: go to IDLE; the new request is dropped.
- Acknowledge cycles while IDLE: ignored, no int_ack.

Optional Feature:
- Macro: SOUND_LATCH_OVERRUN_EN.
- Defined:
  - Adds output overrun_cnt[7:0], reset 0.
  - Increments when a 68K write occurs while latch_pending = 1, including a write coinciding with a read or clear while pending.
  - Saturates at 8'hFF.
  - Debug only.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package tc_sound_pkg holds:
  - localparam IRQ_DIV_DEFAULT = 512
  - localparam LATCH_CLEAR_VAL = 8'h00
  - function latch_encode(input [7:0] d) returning {d[6:0], 1'b1}
- One sub-module is natural: z80_irq_timer, containing the counter plus the IDLE/ASSERTED state machine.
  - Inputs: clk, reset, clk_en_z80, ack qualifier.
  - Outputs: z80_int_n, int_ack.
- Latch logic stays in the top level.

Test Plan:
- Reset then a 68K word write of 16'h00A5 to the latch: latch_dout = 8'h4B and latch_pending = 1 one clk after the strobe edge. Holding the strobe 6 more clks causes no second write.
- After a latch write of 8'h4B, a Z80 read on an enable clk gives latch_pending = 0 with latch_dout still 8'h4B; a following clear gives latch_dout = 8'h00.
- 68K write edge and z80_latch_clr_cs on the same enable clk: latch_dout = new encoded value and latch_pending = 1.
- IRQ_DIV = 8 with continuous enables: z80_int_n falls after the 8th enable. No ack for 24 enables keeps it low with no queueing. M1_n = 0 and IORQ_n = 0 on an enable gives int_ack for 1 clk, z80_int_n = 1, and the next fall 8 enables after the previous one.
- Assert reset while INT is asserted and pending = 1: all outputs return to reset values immediately, without waiting for clk.
- With SOUND_LATCH_OVERRUN_EN, 300 writes without reads: overrun_cnt = 8'hFF; without the macro, the build has no overrun_cnt port.
